first_seq_ctrl: RTL and testbench

FIRST_SEQ_CTRL -- requirements
Module: first_seq_ctrl

---
 rtl/first_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_first_seq_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/first_seq_ctrl.sv
// Sequencer stepping first_in through 0..3 (mod 4), DWELL cycles per value, STEPS values per run.
// Optional sample log: define FIRST_SEQ_LOG_EN to add the 24-bit log output.
module first_seq_ctrl #(
    parameter int DWELL = 10,
    parameter int STEPS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        first_out1,
    input  logic        first_out2,
    input  logic        first_out3,
    output logic [1:0]  first_in,
    output logic        busy,
    output logic        done,
    output logic [3:0]  step_cnt,
    output logic [3:0]  ones_cnt
`ifdef FIRST_SEQ_LOG_EN
    ,
    output logic [23:0] log
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [3:0] STEPS_LAST = 4'(STEPS);

    state_t     state_q, state_d;
    logic [7:0] dwell_q, dwell_d;
    logic [1:0] first_in_d;
    logic [3:0] step_d, ones_d;
    logic       busy_d, done_d;
    logic [2:0] smp;

    assign smp = {first_out3, first_out2, first_out1};

`ifdef FIRST_SEQ_LOG_EN
    logic [23:0] log_d;
`else
    logic unused_smp;
    assign unused_smp = ^smp[2:1];
`endif

    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        first_in_d = first_in;
        step_d     = step_cnt;
        ones_d     = ones_cnt;
`ifdef FIRST_SEQ_LOG_EN
        log_d      = log;
`endif
        case (state_q)
            IDLE: begin
                // abort beats start when both arrive together
                if (start && !abort) begin
                    state_d    = RUN;
                    dwell_d    = 8'd0;
                    first_in_d = 2'd0;
                    step_d     = 4'd0;
                    ones_d     = 4'd0;
`ifdef FIRST_SEQ_LOG_EN
                    log_d      = 24'd0;
`endif
                end
            end
            RUN: begin
                if (abort) begin
                    state_d    = IDLE;
                    dwell_d    = 8'd0;
                    first_in_d = 2'd0;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d    = 8'd0;
                    first_in_d = first_in + 2'd1;
                    step_d     = step_cnt + 4'd1;
                    ones_d     = ones_cnt + {3'd0, smp[0]};
`ifdef FIRST_SEQ_LOG_EN
                    log_d      = {log[20:0], smp};
`endif
                    if (step_cnt + 4'd1 == STEPS_LAST) begin
                        state_d    = DONE;
                        first_in_d = 2'd0;
                    end
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                dwell_d    = 8'd0;
                first_in_d = 2'd0;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dwell_q  <= 8'd0;
            first_in <= 2'd0;
            step_cnt <= 4'd0;
            ones_cnt <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef FIRST_SEQ_LOG_EN
            log      <= 24'd0;
`endif
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            first_in <= first_in_d;
            step_cnt <= step_d;
            ones_cnt <= ones_d;
            busy     <= busy_d;
            done     <= done_d;
`ifdef FIRST_SEQ_LOG_EN
            log      <= log_d;
`endif
        end
    end

endmodule

// File: tb/tb_first_seq_ctrl.sv
// Randomized scoreboard bench for first_seq_ctrl: run results are queued at stimulus time
// and checked by an independent monitor on each done pulse.
module tb_first_seq_ctrl;
    localparam int DWELL = 10;
    localparam int STEPS = 8;
    localparam int LEN   = DWELL * STEPS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0;
    logic o1 = 1'b0, o2 = 1'b0, o3 = 1'b0;
    logic [1:0] first_in;
    logic       busy, done;
    logic [3:0] step_cnt, ones_cnt;
`ifdef FIRST_SEQ_LOG_EN
    logic [23:0] log;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          steps;
        int          ones;
        int          len;
        logic [23:0] lg;
    } exp_t;
    exp_t exp_q[$];

    first_seq_ctrl #(.DWELL(DWELL), .STEPS(STEPS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .first_out1(o1), .first_out2(o2), .first_out3(o3),
        .first_in(first_in), .busy(busy), .done(done),
        .step_cnt(step_cnt), .ones_cnt(ones_cnt)
`ifdef FIRST_SEQ_LOG_EN
        , .log(log)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: per-cycle first_in sequence while busy, and run results on each done.
    initial begin
        int   cyc;
        bit   pb;
        exp_t e;
        cyc = 0;
        pb  = 1'b0;
        forever begin
            @(negedge clk);
            if (busy && !pb) cyc = 0;
            if (busy) begin
                chk("first_in_seq", 32'(first_in), 32'((cyc / DWELL) % 4));
                cyc++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_step_cnt", 32'(step_cnt), 32'(e.steps));
                    chk("done_ones_cnt", 32'(ones_cnt), 32'(e.ones));
                    chk("run_length", 32'(cyc), 32'(e.len));
                    chk("done_busy", 32'(busy), 32'd0);
                    chk("done_first_in", 32'(first_in), 32'd0);
`ifdef FIRST_SEQ_LOG_EN
                    chk("done_log", 32'(log), 32'(e.lg));
`endif
                end
            end
            pb = busy;
        end
    end

    // One run: per-step first_out patterns; optional abort or reset at RUN cycle index.
    task automatic do_run(input logic [STEPS-1:0] p1, input logic [STEPS-1:0] p2,
                          input logic [STEPS-1:0] p3, input int abort_at, input int rst_at,
                          input bit noise);
        exp_t e;
        int   s, n_ok, n_ones;
        bit   stopped;
        e.steps = STEPS;
        e.ones  = $countones(p1);
        e.len   = LEN;
        e.lg    = 24'd0;
        for (int i = 0; i < STEPS; i++) e.lg = {e.lg[20:0], p3[i], p2[i], p1[i]};
        if (abort_at < 0 && rst_at < 0) exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stopped = 1'b0;
        for (int k = 0; k < LEN && !stopped; k++) begin
            s = k / DWELL;
            o1 = p1[s];
            o2 = p2[s];
            o3 = p3[s];
            start = noise ? ($urandom_range(0, 5) == 0) : 1'b0;
            if (k == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                n_ok = abort_at / DWELL;
                n_ones = 0;
                for (int j = 0; j < n_ok; j++) n_ones += int'(p1[j]);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_first_in", 32'(first_in), 32'd0);
                chk("abort_step_cnt", 32'(step_cnt), 32'(n_ok));
                chk("abort_ones_cnt", 32'(ones_cnt), 32'(n_ones));
                stopped = 1'b1;
            end else if (k == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("arst_busy", 32'(busy), 32'd0);
                chk("arst_first_in", 32'(first_in), 32'd0);
                chk("arst_step_cnt", 32'(step_cnt), 32'd0);
                chk("arst_ones_cnt", 32'(ones_cnt), 32'd0);
                start = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                stopped = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        if (stopped) begin
            chk("post_stop_busy", 32'(busy), 32'd0);
        end else begin
            chk("hold_step_cnt", 32'(step_cnt), 32'(STEPS));
            chk("hold_ones_cnt", 32'(ones_cnt), 32'(e.ones));
        end
    endtask

    initial begin
        logic [STEPS-1:0] a, b, c;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_first_in", 32'(first_in), 32'd0);
        chk("rst_step_cnt", 32'(step_cnt), 32'd0);
        chk("rst_ones_cnt", 32'(ones_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("start_abort_idle", 32'(busy), 32'd0);
            @(negedge clk);
        end

        do_run('1, '0, '0, -1, -1, 1'b0);
        for (int i = 0; i < STEPS; i++) begin
            a[i] = (i % 4) & 1;
            b[i] = ((i % 4) >> 1) & 1;
        end
        do_run(a, b, '0, -1, -1, 1'b1);

        for (int r = 0; r < 4; r++) begin
            a = STEPS'($urandom);
            b = STEPS'($urandom);
            c = STEPS'($urandom);
            do_run(a, b, c, -1, -1, 1'b1);
        end

        do_run(STEPS'($urandom), '0, '0, 35, -1, 1'b0);
        do_run(STEPS'($urandom), '0, '0, 39, -1, 1'b1);
        do_run(STEPS'($urandom), '0, '0, -1, 42, 1'b0);
        repeat (15) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(busy), 32'd0);
        end
        chk("post_rst_step_cnt", 32'(step_cnt), 32'd0);

        do_run(STEPS'($urandom), STEPS'($urandom), STEPS'($urandom), -1, -1, 1'b1);

        repeat (5) @(negedge clk);
        chk("pending_done", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
